// File: rtl/hash_regfile_arbiter.sv
// Round-robin owner of the register file bulk hash ports (Keccak / Haraka).
// Optional perf counters enabled by defining HASH_ARB_PERF_EN.
module hash_regfile_arbiter #(
    parameter int MAX_GRANT_CYCLES = 255,
    parameter int DRAIN_CYCLES     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        keccak_req,
    input  logic        keccak_done,
    input  logic [31:0] keccak_we_i,
    input  logic [17:0] keccak_gp_we_i,
    input  logic        haraka_req,
    input  logic        haraka_done,
    input  logic [31:0] haraka_we_i,
    output logic        keccak_gnt,
    output logic        haraka_gnt,
    output logic [31:0] we_hash_o,
    output logic [17:0] we_hash_gp_o,
    output logic [31:0] we_haraka_o,
    output logic        pipeline_stall,
    output logic        timeout_err,
    input  logic        err_clear
`ifdef HASH_ARB_PERF_EN
    ,
    output logic [31:0] perf_k_cycles,
    output logic [31:0] perf_h_cycles,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam logic [15:0] MAX_W   = 16'(MAX_GRANT_CYCLES);
    localparam logic [2:0]  DRAIN_W = 3'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        GRANT_K,
        GRANT_H
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        win_h_q;
    logic        win_h_d;
    logic        last_k_q;
    logic        last_k_d;
    logic [15:0] wd_q;
    logic [15:0] wd_d;
    logic [2:0]  dc_q;
    logic [2:0]  dc_d;
    logic        terr_d;

    // Next-state, winner latch, drain/watchdog counters and error flag.
    always_comb begin
        state_d  = state_q;
        win_h_d  = win_h_q;
        last_k_d = last_k_q;
        wd_d     = wd_q;
        dc_d     = dc_q;
        terr_d   = timeout_err;
        if (err_clear) begin
            terr_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (keccak_req || haraka_req) begin
                    win_h_d = haraka_req && (!keccak_req || last_k_q);
                    dc_d    = 3'd1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dc_q >= DRAIN_W) begin
                    state_d = win_h_q ? GRANT_H : GRANT_K;
                    dc_d    = 3'd0;
                    wd_d    = 16'd1;
                end else begin
                    dc_d = dc_q + 3'd1;
                end
            end
            GRANT_K: begin
                if (keccak_done || wd_q >= MAX_W) begin
                    state_d  = IDLE;
                    last_k_d = 1'b1;
                    wd_d     = 16'd0;
                    if (!keccak_done) begin
                        terr_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            GRANT_H: begin
                if (haraka_done || wd_q >= MAX_W) begin
                    state_d  = IDLE;
                    last_k_d = 1'b0;
                    wd_d     = 16'd0;
                    if (!haraka_done) begin
                        terr_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; grant/stall outputs registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            win_h_q        <= 1'b0;
            last_k_q       <= 1'b0;
            wd_q           <= 16'd0;
            dc_q           <= 3'd0;
            keccak_gnt     <= 1'b0;
            haraka_gnt     <= 1'b0;
            pipeline_stall <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_h_q        <= win_h_d;
            last_k_q       <= last_k_d;
            wd_q           <= wd_d;
            dc_q           <= dc_d;
            keccak_gnt     <= (state_d == GRANT_K);
            haraka_gnt     <= (state_d == GRANT_H);
            pipeline_stall <= (state_d != IDLE);
            timeout_err    <= terr_d;
        end
    end

    assign we_hash_o    = keccak_we_i & {32{keccak_gnt}};
    assign we_hash_gp_o = keccak_gp_we_i & {18{keccak_gnt}};
    assign we_haraka_o  = haraka_we_i & {32{haraka_gnt}};

`ifdef HASH_ARB_PERF_EN
    // Saturating cycle counters for grant ownership and stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_k_cycles     <= 32'd0;
            perf_h_cycles     <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (keccak_gnt && perf_k_cycles != 32'hFFFF_FFFF) begin
                perf_k_cycles <= perf_k_cycles + 32'd1;
            end
            if (haraka_gnt && perf_h_cycles != 32'hFFFF_FFFF) begin
                perf_h_cycles <= perf_h_cycles + 32'd1;
            end
            if (pipeline_stall && perf_stall_cycles != 32'hFFFF_FFFF) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
